serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer for a bit-serial adder that time-shares one full-adder slice, built from two HalfAdder-style XOR/AND stages, across a WIDTH-bit operand pair.
- Accepts an operand pair on a START/READY handshake and processes one bit per clock, LSB first.
- Presents the WIDTH-bit sum and carry-out under a DONE/ACK handshake.
- Sits between a requester and the shared adder slice; it is the datapath's only controller.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- CLK  input  1  single system clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin an addition; sampled only when READY=1.
- A  input  WIDTH  operand A; captured on accept.
- B  input  WIDTH  operand B; captured on accept.
- READY  output  1  high in IDLE only; an addition can be accepted.
- BUSY  output  1  high in RUN only.
- DONE  output  1  high in DONE state; S and C are valid.
- ACK  input  1  requester has consumed the result; sampled only when DONE=1.
- S  output  WIDTH  sum A+B mod 2^WIDTH.
- C  output  1  carry-out of A+B.

Behaviour:
- Reset (RST=1, asynchronous, any state):
  - State goes to IDLE immediately.
  - READY=1, BUSY=0, DONE=0, S=0, C=0.
  - Operand shift registers, carry flop and bit counter are cleared.
- State machine (3 states: IDLE, RUN, DONE):
  - IDLE: READY=1. START=1 at an edge accepts the request:
    - latch A and B into shift registers;
    - clear the carry flop, the bit counter, S and C;
    - go to RUN.
  - RUN: each edge processes bit i (counter value):
    - half-adder 1: p = a[i] ^ b[i], g = a[i] & b[i];
    - half-adder 2: s = p ^ cy, t = p & cy;
    - cy_next = g | t;
    - s is shifted into S from the MSB side (right shift), so after WIDTH bits S[i] holds bit i;
    - the counter increments.
    - On the edge processing bit WIDTH-1: C <= cy_next and go to DONE.
  - DONE: DONE=1; S and C are stable. ACK=1 at an edge goes to IDLE.
- Latency:
  - Request accepted at edge k gives DONE=1 after edge k+WIDTH.
  - ACK sampled at edge m gives READY=1 after edge m.
  - Minimum request-to-request spacing is WIDTH+2 cycles.
- Handshake and boundary rules:
  - START while READY=0 (RUN or DONE) is ignored and is not queued.
  - ACK outside DONE is ignored.
  - START and ACK both high in DONE: ACK is honoured, START is ignored (READY was 0). If START is still high one cycle later in IDLE, it is accepted then.
  - A and B may change freely after the accept edge; the captured values are used.
  - S and C keep the last result through IDLE until the next accept clears them.
  - Counter terminal value is WIDTH-1; the counter wraps to 0 on entry to RUN, never mid-operation.
  - Carry out of bit WIDTH-1 goes to C only, never into S.
  - Reset asserted mid-RUN or in DONE aborts the operation and discards partial S. After reset release the first edge sees IDLE.
- Outputs READY, BUSY and DONE are decoded from registered state only, with no combinational path from inputs.
- Exactly one of READY, BUSY, DONE is high at any time outside reset.

Test Plan:
- WIDTH=8, A=0x00, B=0x00, START pulsed at edge k:
  - BUSY high after edge k for 8 cycles;
  - DONE=1 after edge k+8 with S=0x00, C=0;
  - ACK gives READY=1 next cycle.
- A=0xFF, B=0x01: S=0x00, C=1. Then A=0x80, B=0x80: S=0x00, C=1. Then A=0xA5, B=0x5A: S=0xFF, C=0.
- Accept A=0x3C, B=0x0F, then change A/B to 0xFF/0xFF and pulse START during RUN:
  - result is still S=0x4B, C=0;
  - no second operation starts.
- START and ACK held high continuously with A=0x01, B=0x02:
  - each operation shows DONE for exactly 1 cycle, then IDLE for 1 cycle, then RUN;
  - period is 10 cycles; S=0x03 each time.
- Assert RST asynchronously (between edges) on the 3rd RUN cycle:
  - READY=1, BUSY=0, DONE=0, S=0, C=0 immediately;
  - the next request A=0x10, B=0x20 gives S=0x30, C=0.
- ACK pulsed in IDLE and RUN: no state change. Hold DONE for 5 cycles without ACK: S and C stay stable.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for the bit-serial adder sequencer.
// master : requester (drives START, A, B, ACK; observes READY, BUSY, DONE, S, C)
// slave  : serial_add_ctrl (the sequencer itself)
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ACK;
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             C;

    modport master (
        output START, A, B, ACK,
        input  READY, BUSY, DONE, S, C
    );

    modport slave (
        input  START, A, B, ACK,
        output READY, BUSY, DONE, S, C
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: one full-adder slice (two half-adder
// stages) is reused across WIDTH bits, LSB first, one bit per clock.
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous, active-high reset
//   bus  - slave side of serial_add_ctrl_if:
//          START/READY accept handshake, A/B operands,
//          DONE/ACK result handshake, S sum, C carry-out,
//          BUSY high while bits are being processed.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | READY=1, waiting for START; last S/C still shown
// RUN     | BUSY=1, one operand bit processed per clock
// DONE    | DONE=1, S/C valid, waiting for ACK
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_reg;
    logic             c_reg;

    // Shared full-adder slice built from two half-adder stages.
    logic p, g, t, s_bit, cy_next;

    assign p       = a_sh[0] ^ b_sh[0];
    assign g       = a_sh[0] & b_sh[0];
    assign s_bit   = p ^ cy;
    assign t       = p & cy;
    assign cy_next = g | t;

    assign bus.READY = (state == ST_IDLE);
    assign bus.BUSY  = (state == ST_RUN);
    assign bus.DONE  = (state == ST_DONE);
    assign bus.S     = s_reg;
    assign bus.C     = c_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            s_reg <= '0;
            c_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        cy    <= 1'b0;
                        cnt   <= '0;
                        s_reg <= '0;
                        c_reg <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cy    <= cy_next;
                    // Sum bits enter at the MSB so bit i lands at S[i] after WIDTH shifts.
                    s_reg <= {s_bit, s_reg[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        // Final carry goes to C only; counter parked at 0 for the next run.
                        cnt   <= '0;
                        c_reg <= cy_next;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.ACK) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.READY, bus.BUSY, bus.DONE};
    endfunction

    // One full transaction; expected result from plain integer addition.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit poke_run, input bit ack_in_run, input int hold_done);
        int          wait_cyc;
        int          cyc;
        logic [8:0]  sum;
        sum = {1'b0, a} + {1'b0, b};
        wait_cyc = 0;
        while (!bus.READY && wait_cyc < 20) begin
            @(negedge CLK);
            wait_cyc++;
        end
        chk("ready_before_start", {31'd0, bus.READY}, 32'd1);
        bus.A = a;
        bus.B = b;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        cyc = 0;
        while (bus.BUSY && cyc < 40) begin
            if (poke_run && cyc == 1) begin
                bus.A = 8'hFF;
                bus.B = 8'hFF;
                bus.START = 1'b1;
            end else begin
                bus.START = 1'b0;
            end
            bus.ACK = (ack_in_run && cyc == 2);
            @(negedge CLK);
            cyc++;
        end
        bus.START = 1'b0;
        bus.ACK = 1'b0;
        chk("busy_cycles", cyc, 32'd8);
        chk("flags_done", {29'd0, flags()}, 32'b001);
        chk("sum", {24'd0, bus.S}, {24'd0, sum[7:0]});
        chk("carry", {31'd0, bus.C}, {31'd0, sum[8]});
        for (int i = 0; i < hold_done; i++) begin
            @(negedge CLK);
            chk("hold_done", {29'd0, flags()}, 32'b001);
            chk("hold_sum", {23'd0, bus.C, bus.S}, {23'd0, sum});
        end
        bus.ACK = 1'b1;
        @(negedge CLK);
        bus.ACK = 1'b0;
        chk("ready_after_ack", {29'd0, flags()}, 32'b100);
        chk("sum_kept_idle", {23'd0, bus.C, bus.S}, {23'd0, sum});
        if (poke_run) begin
            @(negedge CLK);
            chk("no_queued_start", {29'd0, flags()}, 32'b100);
        end
    endtask

    initial begin
        logic [8:0] rsum;
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        bus.START = 1'b0;
        bus.ACK = 1'b0;
        bus.A = '0;
        bus.B = '0;

        @(negedge CLK);
        @(negedge CLK);
        chk("reset_flags", {29'd0, flags()}, 32'b100);
        chk("reset_sc", {23'd0, bus.C, bus.S}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_after_reset", {29'd0, flags()}, 32'b100);

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b0, 1'b0, 0);

        // Operand change and stray START during RUN.
        run_op(8'h3C, 8'h0F, 1'b1, 1'b0, 0);

        // START and ACK held: 8 RUN, 1 DONE, 1 IDLE, repeating.
        bus.A = 8'h01;
        bus.B = 8'h02;
        bus.START = 1'b1;
        bus.ACK = 1'b1;
        @(negedge CLK);
        for (int j = 0; j < 30; j++) begin
            logic [2:0] exp_f;
            exp_f = (j % 10 < 8) ? 3'b010 : ((j % 10 == 8) ? 3'b001 : 3'b100);
            chk("stream_flags", {29'd0, flags()}, {29'd0, exp_f});
            if (exp_f == 3'b001)
                chk("stream_sum", {23'd0, bus.C, bus.S}, 32'h003);
            if (j < 29) @(negedge CLK);
        end
        bus.START = 1'b0;
        bus.ACK = 1'b0;
        @(negedge CLK);
        chk("stream_stop", {29'd0, flags()}, 32'b100);

        // Asynchronous reset on the 3rd RUN cycle.
        bus.A = 8'h77;
        bus.B = 8'h11;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_reset_busy", {29'd0, flags()}, 32'b010);
        #2 RST = 1'b1;
        #1;
        chk("async_reset_flags", {29'd0, flags()}, 32'b100);
        chk("async_reset_sc", {23'd0, bus.C, bus.S}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 0);

        // ACK in IDLE ignored.
        bus.ACK = 1'b1;
        @(negedge CLK);
        bus.ACK = 1'b0;
        chk("ack_in_idle", {29'd0, flags()}, 32'b100);

        // ACK during RUN ignored, DONE held 5 cycles without ACK.
        run_op(8'hC3, 8'h7E, 1'b0, 1'b1, 5);

        for (int k = 0; k < 20; k++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0, k % 2);
        end

        rsum = 9'd0;
        chk("final_idle", {29'd0, flags()}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
